s27_seq_array: RTL and testbench
================================

# s27_seq_array

Parametrised sequential successor to the s27 combinational core. It holds CHANNELS independent s27 machines, each with its own three state flops closed around the s27 next-state logic. All channel responses feed a multiple-input signature register (MISR) for response compaction. An optional scan chain threads every state flop. It sits in the test-benchmark area as the device-under-test for fault-simulation and BIST experiments.

## Interface
- CHANNELS, 4: number of independent s27 machines, 1..SIG_W.
- SIG_W, 16: MISR width, 2..32.
- SIG_POLY, 16'h1021: MISR feedback taps, SIG_W bits wide. Bit k XORs into bit k when the MSB shifts out.
- clk  in  1  single rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  functional state update enable.
- g0, g1, g2, g3  in  CHANNELS each  primary inputs. Bit i drives channel i.
- sig_en  in  1  MISR update enable.
- sig_clr  in  1  synchronous MISR clear.
- scan_en  in  1  scan shift mode.
- scan_in  in  1  scan serial input.
- g17  out  CHANNELS  primary output per channel. Combinational (Mealy).
- state_q  out  3*CHANNELS  state flops. Channel i occupies bits [3i+2:3i] = {G7,G6,G5}.
- sig_q  out  SIG_W  MISR contents.
- scan_out  out  1  scan serial output.

## Operation
- Per channel, with G5/G6/G7 taken from that channel's flops:
  - G14=~G0
  - G8=G14&G6
  - G12=~(G1|G7)
  - G15=G12|G8
  - G16=G3|G8
  - G9=~(G16&G15)
  - G11=~(G5|G9)
  - G10=~(G14|G11)
  - G13=~(G2|G12)
  - g17=~G11
- Functional update when scan_en=0 and en=1: G5<=G10, G6<=G11, G7<=G13.
- When scan_en=0 and en=0: all state holds.
- Scan (scan_en=1) is the highest priority and ignores en.
  - The chain shifts one bit per cycle in order ch0.G5 -> ch0.G6 -> ch0.G7 -> ch1.G5 -> … -> ch(N-1).G7.
  - scan_in enters ch0.G5.
  - scan_out equals ch(N-1).G7 directly from the flop.
- MISR update, evaluated in priority order each cycle:
  - sig_clr=1: sig<=0. Clear beats sig_en.
  - Else if sig_en=1 and scan_en=0: sig <= (sig<<1) ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zext(g17).
  - Otherwise: hold.
- The MISR samples the g17 value present in the same cycle, i.e. the values computed from pre-update state.

## Timing
- Reset (async assert, synchronous-to-clk deassert handled upstream): state_q=0, sig_q=0, scan_out=0.
- g17 is live during reset. With state 0 and g0..g3=0, g17=1.
- Next-state latency is 1 cycle.
- g17 has zero-cycle latency from g0..g3 and one cycle from state.
- sig_q reflects a response one cycle after the response appears on g17.
- A full scan load or unload takes 3*CHANNELS cycles.
- Reset asserted mid-shift or mid-compaction clears everything immediately; no partial state survives.
- en, sig_en and scan_en may toggle on any cycle, with no recovery cycles.

## Configuration
- S27_SEQ_SCAN_EN defined: scan chain behaves as above.
- S27_SEQ_SCAN_EN undefined:
  - scan_en and scan_in remain as ports but are ignored.
  - scan_out is tied to 0.
  - The MISR treats scan_en as 0.
  - No scan muxes are inferred.

## Structure
- Package s27_pkg holds:
  - the state-index constants (IDX_G5=0, IDX_G6=1, IDX_G7=2);
  - STATE_BITS=3;
  - the default SIG_POLY;
  - a packed struct for the per-channel state.
- Sub-module s27_core: purely combinational s27 logic. Inputs are g0..g3 and {G7,G6,G5}. Outputs are next state {G13,G11,G10} and g17. Instantiated CHANNELS times by generate.
- Flops, scan muxing and the MISR live in the top module.

## Test plan
- Reset, CHANNELS=1, g0..g3=0, en=1 → state_q stays 3'b000 and g17=1 every cycle.
- From state 000, g0=1, g1=0, g2=0, g3=1, en=1 → g17=0 and state_q becomes {G7,G6,G5}=3'b010 after one edge; it holds 010 on repeat. Then set g0..g3=0 → g17=0 and state stays 010.
- MISR: CHANNELS=1, SIG_W=16, inputs 0 from reset, sig_en=1 → sig_q = 1, 3, 7, 15 on successive cycles. A sig_clr pulse returns sig_q to 0 even with sig_en=1.
- en=0 with the inputs of scenario 2 → state_q holds 000 indefinitely while g17 still shows 0.
- S27_SEQ_SCAN_EN, CHANNELS=2: shift pattern 101100 in six cycles, then drop scan_en → state_q=6'b001101. Six further shifts reproduce the pattern on scan_out, and sig_q is unchanged throughout.
- rst_n asserted mid-scan and mid-compaction → state_q, sig_q and scan_out are 0 in the same cycle, before the next clock edge.

Source files
------------

// File: rtl/s27_pkg.sv
// s27_pkg: shared constants and types for the s27 sequential array.
// State-bit indices, state width, default MISR taps, per-channel state struct.
package s27_pkg;

    localparam int IDX_G5     = 0;
    localparam int IDX_G6     = 1;
    localparam int IDX_G7     = 2;
    localparam int STATE_BITS = 3;

    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;

    // Packed so that {g7,g6,g5} lands on bits [2:0] in index order.
    typedef struct packed {
        logic g7;
        logic g6;
        logic g5;
    } s27_state_t;

endpackage

// File: rtl/s27_core.sv
// s27_core: combinational s27 next-state and output logic for one channel.
// Ports: g0_i..g3_i primary inputs, state_i {G7,G6,G5},
//        next_o {G13,G11,G10}, g17_o primary output.
module s27_core
    import s27_pkg::*;
(
    input  logic       g0_i,
    input  logic       g1_i,
    input  logic       g2_i,
    input  logic       g3_i,
    input  s27_state_t state_i,
    output s27_state_t next_o,
    output logic       g17_o
);

    logic g8, g9, g10, g11, g12;
    logic g13, g14, g15, g16;

    assign g14 = ~g0_i;
    assign g8  = g14 & state_i.g6;
    assign g12 = ~(g1_i | state_i.g7);
    assign g15 = g12 | g8;
    assign g16 = g3_i | g8;
    assign g9  = ~(g16 & g15);
    assign g11 = ~(state_i.g5 | g9);
    assign g10 = ~(g14 | g11);
    assign g13 = ~(g2_i | g12);

    assign next_o.g7 = g13;
    assign next_o.g6 = g11;
    assign next_o.g5 = g10;
    assign g17_o     = ~g11;

endmodule

// File: rtl/s27_seq_array.sv
// s27_seq_array: CHANNELS independent s27 machines, MISR response
// compaction and an optional scan chain through all state flops.
// Optional feature macro: S27_SEQ_SCAN_EN (scan chain enabled when defined).
// Ports: clk, rst_n (async low), en, g0..g3 [CHANNELS], sig_en, sig_clr,
//        scan_en, scan_in; outputs g17 [CHANNELS], state_q [3*CHANNELS],
//        sig_q [SIG_W], scan_out.
module s27_seq_array
    import s27_pkg::*;
#(
    parameter int               CHANNELS = 4,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [CHANNELS-1:0]            g0,
    input  logic [CHANNELS-1:0]            g1,
    input  logic [CHANNELS-1:0]            g2,
    input  logic [CHANNELS-1:0]            g3,
    input  logic                           sig_en,
    input  logic                           sig_clr,
    input  logic                           scan_en,
    input  logic                           scan_in,
    output logic [CHANNELS-1:0]            g17,
    output logic [STATE_BITS*CHANNELS-1:0] state_q,
    output logic [SIG_W-1:0]               sig_q,
    output logic                           scan_out
);

    localparam int NB = STATE_BITS * CHANNELS;

    logic [NB-1:0]    nxt;
    logic [NB-1:0]    state_d;
    logic [SIG_W-1:0] sig_d;
    logic             scan_act;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        s27_state_t cur;
        s27_state_t nx;

        assign cur = state_q[STATE_BITS*ch +: STATE_BITS];

        s27_core u_core (
            .g0_i    (g0[ch]),
            .g1_i    (g1[ch]),
            .g2_i    (g2[ch]),
            .g3_i    (g3[ch]),
            .state_i (cur),
            .next_o  (nx),
            .g17_o   (g17[ch])
        );

        assign nxt[STATE_BITS*ch +: STATE_BITS] = nx;
    end

`ifdef S27_SEQ_SCAN_EN
    assign scan_act = scan_en;
    assign scan_out = state_q[NB-1];

    // Chain runs from ch0.G5 (bit 0) up to ch(N-1).G7 (top bit).
    always_comb begin
        state_d = state_q;
        if (scan_act) begin
            state_d = {state_q[NB-2:0], scan_in};
        end else if (en) begin
            state_d = nxt;
        end
    end
`else
    logic unused_scan;

    assign unused_scan = scan_en ^ scan_in;
    assign scan_act    = 1'b0;
    assign scan_out    = 1'b0;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = nxt;
        end
    end
`endif

    // MISR compacts the g17 seen this cycle (pre-update state).
    always_comb begin
        sig_d = sig_q;
        if (sig_clr) begin
            sig_d = '0;
        end else if (sig_en && !scan_act) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(g17);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
        end
    end

endmodule

// File: tb/tb_s27_seq_array.sv
// tb_s27_seq_array: directed self-checking bench for s27_seq_array.
// Uses a 1-channel instance and a 2-channel instance sharing clk/rst_n.
module tb_s27_seq_array;

    logic clk;
    logic rst_n;

    logic        en1, sig_en1, sig_clr1, scan_en1, scan_in1;
    logic        g0_1, g1_1, g2_1, g3_1;
    logic        g17_1;
    logic [2:0]  st1;
    logic [15:0] sig1;
    logic        so1;

    logic        en2, sig_en2, sig_clr2, scan_en2, scan_in2;
    logic [1:0]  g0_2, g1_2, g2_2, g3_2;
    logic [1:0]  g17_2;
    logic [5:0]  st2;
    logic [15:0] sig2;
    logic        so2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    s27_seq_array #(.CHANNELS(1), .SIG_W(16), .SIG_POLY(16'h1021)) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en1),
        .g0       (g0_1),
        .g1       (g1_1),
        .g2       (g2_1),
        .g3       (g3_1),
        .sig_en   (sig_en1),
        .sig_clr  (sig_clr1),
        .scan_en  (scan_en1),
        .scan_in  (scan_in1),
        .g17      (g17_1),
        .state_q  (st1),
        .sig_q    (sig1),
        .scan_out (so1)
    );

    s27_seq_array #(.CHANNELS(2), .SIG_W(16), .SIG_POLY(16'h1021)) u2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en2),
        .g0       (g0_2),
        .g1       (g1_2),
        .g2       (g2_2),
        .g3       (g3_2),
        .sig_en   (sig_en2),
        .sig_clr  (sig_clr2),
        .scan_en  (scan_en2),
        .scan_in  (scan_in2),
        .g17      (g17_2),
        .state_q  (st2),
        .sig_q    (sig2),
        .scan_out (so2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: asserts reset at +4, releases at +7.
    task automatic rst_assert();
        #3 rst_n = 1'b0;
        #1;
    endtask

    task automatic rst_release();
        #2 rst_n = 1'b1;
    endtask

    logic [5:0] p;

    initial begin
        rst_n = 1'b0;
        {en1, sig_en1, sig_clr1, scan_en1, scan_in1} = '0;
        {g0_1, g1_1, g2_1, g3_1} = '0;
        {en2, sig_en2, sig_clr2, scan_en2, scan_in2} = '0;
        {g0_2, g1_2, g2_2, g3_2} = '0;
        #12;
        chk("rst_state1", st1, 0);
        chk("rst_sig1", sig1, 0);
        chk("rst_g17_1", g17_1, 1);
        chk("rst_state2", st2, 0);
        chk("rst_scan_out2", so2, 0);
        rst_n = 1'b1;
        en1   = 1'b1;

        repeat (2) begin
            tick();
            chk("idle_state", st1, 0);
            chk("idle_g17", g17_1, 1);
        end

        sig_en1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("misr_ramp", sig1, (32'h1 << (k + 1)) - 1);
        end
        tick();
        chk("misr_poly", sig1, 32'hEFDE);
        sig_en1 = 1'b0;
        tick();
        chk("misr_hold", sig1, 32'hEFDE);
        sig_clr1 = 1'b1;
        sig_en1  = 1'b1;
        tick();
        chk("misr_clr", sig1, 0);
        sig_clr1 = 1'b0;
        sig_en1  = 1'b0;

        g0_1 = 1'b1; g3_1 = 1'b1;
        #1 chk("s2_g17", g17_1, 0);
        tick();
        chk("s2_state", st1, 3'b010);
        tick();
        chk("s2_repeat", st1, 3'b010);
        g0_1 = 1'b0; g3_1 = 1'b0;
        #1 chk("s2_zero_g17", g17_1, 0);
        tick();
        chk("s2_zero_state", st1, 3'b010);

        g0_1 = 1'b1;
        #1 chk("t001_g17", g17_1, 1);
        tick();
        chk("t001_state", st1, 3'b001);
        g0_1 = 1'b0;
        tick();
        chk("t000_state", st1, 3'b000);
        g1_1 = 1'b1;
        tick();
        chk("t100_state", st1, 3'b100);
        g1_1 = 1'b0;
        tick();
        chk("t100_hold", st1, 3'b100);
        g2_1 = 1'b1;
        tick();
        chk("t100_exit", st1, 3'b000);
        g2_1 = 1'b0;

        en1 = 1'b0;
        g0_1 = 1'b1; g3_1 = 1'b1;
        #1 chk("en0_g17", g17_1, 0);
        repeat (3) begin
            tick();
            chk("en0_hold", st1, 3'b000);
        end
        chk("en0_g17_late", g17_1, 0);

        g0_1 = 1'b0; g3_1 = 1'b0;
        en1 = 1'b1;
        sig_en1 = 1'b1;
        tick();
        tick();
        chk("mid_sig_pre", sig1, 3);
        g0_1 = 1'b1; g3_1 = 1'b1;
        tick();
        chk("mid_state_pre", st1, 3'b010);
        chk("mid_sig_pre2", sig1, 6);
        rst_assert();
        chk("mid_rst_state", st1, 0);
        chk("mid_rst_sig", sig1, 0);
        chk("mid_rst_g17", g17_1, 0);
        rst_release();
        {en1, sig_en1, g0_1, g3_1} = '0;

        g0_2 = 2'b01; g3_2 = 2'b01; g1_2 = 2'b10;
        en2 = 1'b1;
        #1 chk("ch2_g17", g17_2, 2'b10);
        tick();
        chk("ch2_state", st2, 6'b100010);
        {g0_2, g1_2, g2_2, g3_2} = '0;
        rst_assert();
        chk("ch2_rst", st2, 0);
        rst_release();

`ifdef S27_SEQ_SCAN_EN
        en2 = 1'b1;
        sig_en2 = 1'b1;
        tick();
        chk("scan_sig_seed", sig2, 3);
        scan_en2 = 1'b1;
        p = 6'b101100;
        for (int i = 0; i < 6; i++) begin
            scan_in2 = p[i];
            tick();
            chk("scan_load_sig", sig2, 3);
        end
        chk("scan_load_state", st2, 6'b001101);
        scan_en2 = 1'b0;
        en2 = 1'b0;
        sig_en2 = 1'b0;
        tick();
        chk("scan_park", st2, 6'b001101);
        scan_en2 = 1'b1;
        sig_en2 = 1'b1;
        scan_in2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("scan_unload", so2, p[i]);
            tick();
        end
        chk("scan_unload_sig", sig2, 3);
        chk("scan_unload_state", st2, 0);
        scan_in2 = 1'b1;
        repeat (6) tick();
        chk("scan_ones", so2, 1);
        chk("scan_ones_state", st2, 6'b111111);
        rst_assert();
        chk("scan_rst_state", st2, 0);
        chk("scan_rst_out", so2, 0);
        chk("scan_rst_sig", sig2, 0);
        rst_release();
`else
        scan_en2 = 1'b1;
        scan_in2 = 1'b1;
        en2 = 1'b1;
        sig_en2 = 1'b1;
        tick();
        chk("noscan_state", st2, 0);
        chk("noscan_out", so2, 0);
        chk("noscan_sig", sig2, 3);
        tick();
        chk("noscan_sig2", sig2, 5);
        g0_2 = 2'b11; g3_2 = 2'b11;
        tick();
        chk("noscan_func", st2, 6'b010010);
        chk("noscan_out2", so2, 0);
        chk("noscan_sig3", sig2, 32'hA);
        rst_assert();
        chk("noscan_rst_state", st2, 0);
        chk("noscan_rst_sig", sig2, 0);
        rst_release();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
